// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the two-master memory-port arbiter.
package bus_arbiter_pkg;

    // Request types carried on the downstream bus.
    localparam logic [1:0] REQ_READ  = 2'b00;
    localparam logic [1:0] REQ_WRITE = 2'b01;

    // Response code for a clean completion.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Owner / grant-id encoding, also driven on bus_owner.
    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StBusyIf  = 2'b01,
        StBusyMem = 2'b10
    } arb_state_t;

    // Busy state that corresponds to a given owner.
    function automatic arb_state_t busy_state(input logic owner);
        return (owner == OWNER_MEM) ? StBusyMem : StBusyIf;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: on contention, grants the input that did not win last time.
module rr_pick2
    import bus_arbiter_pkg::*;
(
    input  logic valid_if,
    input  logic valid_mem,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    // Pick a winner from the current valids and the previous grant.
    always_comb begin
        gnt_valid = valid_if | valid_mem;
        gnt_id    = OWNER_IF;
        if (valid_if && valid_mem) begin
            gnt_id = (last_grant == OWNER_IF) ? OWNER_MEM : OWNER_IF;
        end else if (valid_mem) begin
            gnt_id = OWNER_MEM;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one downstream bus between the fetch port and the data port. A granted request is
// latched and held until bus_ready; requests dropped mid-flight are absorbed silently.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [1:0]        if_size,
    output logic              if_ready,
    output logic [1:0]        if_resp,
    output logic [DATA_W-1:0] if_data_read,

    input  logic              mem_valid,
    input  logic [1:0]        mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_write,
    input  logic [1:0]        mem_size,
    output logic              mem_ready,
    output logic [1:0]        mem_resp,
    output logic [DATA_W-1:0] mem_data_read,

    output logic              bus_valid,
    output logic [1:0]        bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_size,
    input  logic              bus_ready,
    input  logic [1:0]        bus_resp,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_owner
);

    arb_state_t        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              abandon_q, abandon_d;
    logic              bus_valid_q, bus_valid_d;
    logic [1:0]        bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]        bus_size_q, bus_size_d;

    logic gnt_valid;
    logic gnt_id;
    logic owner_valid;
    logic busy;
    logic deliver;

    rr_pick2 u_pick (
        .valid_if   (if_valid),
        .valid_mem  (mem_valid),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Valid of whichever port currently owns the bus; only meaningful while busy.
    assign busy        = (state_q == StBusyIf) || (state_q == StBusyMem);
    assign owner_valid = (state_q == StBusyMem) ? mem_valid : if_valid;

    // Grant in idle, hold the latched request while busy, track abandonment.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        abandon_d    = abandon_q;
        bus_valid_d  = bus_valid_q;
        bus_req_d    = bus_req_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_size_d   = bus_size_q;

        unique case (state_q)
            StIdle: begin
                // bus_ready here is a stray completion and is ignored.
                if (gnt_valid) begin
                    state_d      = busy_state(gnt_id);
                    last_grant_d = gnt_id;
                    abandon_d    = 1'b0;
                    bus_valid_d  = 1'b1;
                    if (gnt_id == OWNER_MEM) begin
                        bus_req_d   = mem_req;
                        bus_addr_d  = mem_addr;
                        bus_wdata_d = mem_data_write;
                        bus_size_d  = mem_size;
                    end else begin
                        // Fetch is read-only; never leak stale store data downstream.
                        bus_req_d   = REQ_READ;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        bus_size_d  = if_size;
                    end
                end
            end
            StBusyIf, StBusyMem: begin
                if (bus_ready) begin
                    // Always pass through idle so a just-completed stale valid is not re-granted.
                    state_d     = StIdle;
                    bus_valid_d = 1'b0;
                    abandon_d   = 1'b0;
                end else if (!owner_valid) begin
                    abandon_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                bus_valid_d = 1'b0;
                abandon_d   = 1'b0;
            end
        endcase
    end

    // State and latched bus request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= OWNER_IF;
            abandon_q    <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_req_q    <= REQ_READ;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_size_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            abandon_q    <= abandon_d;
            bus_valid_q  <= bus_valid_d;
            bus_req_q    <= bus_req_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_size_q   <= bus_size_d;
        end
    end

    // Completion is forwarded only if the owner is still waiting for it.
    assign deliver = busy && bus_ready && !abandon_q;

    // Route the downstream response combinationally to the owning port; the other port sees 0.
    always_comb begin
        if_ready      = 1'b0;
        if_resp       = RESP_OKAY;
        if_data_read  = '0;
        mem_ready     = 1'b0;
        mem_resp      = RESP_OKAY;
        mem_data_read = '0;
        if (deliver) begin
            if (state_q == StBusyMem) begin
                mem_ready     = 1'b1;
                mem_resp      = bus_resp;
                mem_data_read = bus_rdata;
            end else begin
                if_ready     = 1'b1;
                if_resp      = bus_resp;
                if_data_read = bus_rdata;
            end
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_req   = bus_req_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_size  = bus_size_q;
    // The last grant is exactly the current or most recent owner.
    assign bus_owner = last_grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected grants and responses,
// negedge monitors pop and compare whenever the DUT presents them.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid;
    logic [AW-1:0] if_addr;
    logic [1:0]    if_size;
    logic          if_ready;
    logic [1:0]    if_resp;
    logic [DW-1:0] if_data_read;
    logic          mem_valid;
    logic [1:0]    mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_write;
    logic [1:0]    mem_size;
    logic          mem_ready;
    logic [1:0]    mem_resp;
    logic [DW-1:0] mem_data_read;
    logic          bus_valid;
    logic [1:0]    bus_req;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [1:0]    bus_size;
    logic          bus_ready;
    logic [1:0]    bus_resp;
    logic [DW-1:0] bus_rdata;
    logic          bus_owner;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_addr        (if_addr),
        .if_size        (if_size),
        .if_ready       (if_ready),
        .if_resp        (if_resp),
        .if_data_read   (if_data_read),
        .mem_valid      (mem_valid),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data_write (mem_data_write),
        .mem_size       (mem_size),
        .mem_ready      (mem_ready),
        .mem_resp       (mem_resp),
        .mem_data_read  (mem_data_read),
        .bus_valid      (bus_valid),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_size       (bus_size),
        .bus_ready      (bus_ready),
        .bus_resp       (bus_resp),
        .bus_rdata      (bus_rdata),
        .bus_owner      (bus_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          owner;
        logic [1:0]    req;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    size;
    } gnt_t;

    typedef struct {
        logic          port;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    gnt_t eg;
    rsp_t er;
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_bv = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input logic o, input logic [1:0] r, input logic [AW-1:0] a,
                            input logic [DW-1:0] w, input logic [1:0] s);
        gnt_t g;
        g.owner = o; g.req = r; g.addr = a; g.wdata = w; g.size = s;
        gnt_q.push_back(g);
    endtask

    task automatic push_rsp(input logic p, input logic [1:0] r, input logic [DW-1:0] d);
        rsp_t x;
        x.port = p; x.resp = r; x.data = d;
        rsp_q.push_back(x);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_valid) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Wait for a grant, idle 'gap' cycles, then answer with one bus_ready pulse.
    task automatic complete(input int unsigned gap, input logic [1:0] resp,
                            input logic [DW-1:0] rdata, input bit drop_if, input bit drop_mem);
        bit ok;
        wait_grant(ok);
        check("grant_timeout", 64'(ok), 64'd1);
        repeat (gap) step();
        bus_ready = 1'b1;
        bus_resp  = resp;
        bus_rdata = rdata;
        step();
        bus_ready = 1'b0;
        bus_resp  = 2'b00;
        bus_rdata = '0;
        if (drop_if) if_valid = 1'b0;
        if (drop_mem) mem_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bus_valid"}, 64'(bus_valid), 64'd0);
        check({tag, "_bus_req"}, 64'(bus_req), 64'd0);
        check({tag, "_bus_addr"}, bus_addr, 64'd0);
        check({tag, "_bus_wdata"}, bus_wdata, 64'd0);
        check({tag, "_bus_size"}, 64'(bus_size), 64'd0);
        check({tag, "_bus_owner"}, 64'(bus_owner), 64'd0);
        check({tag, "_if_ready"}, 64'(if_ready), 64'd0);
        check({tag, "_if_resp"}, 64'(if_resp), 64'd0);
        check({tag, "_if_data"}, if_data_read, 64'd0);
        check({tag, "_mem_ready"}, 64'(mem_ready), 64'd0);
        check({tag, "_mem_resp"}, 64'(mem_resp), 64'd0);
        check({tag, "_mem_data"}, mem_data_read, 64'd0);
    endtask

    // Grant monitor: every rising bus_valid must match the next expected grant.
    always @(negedge clk) begin
        if (bus_valid && !prev_bv) begin
            vectors++;
            if (gnt_q.size() == 0) begin
                miscompares++;
                $display("FAIL grant: unexpected grant owner=%0d addr=%h, none expected",
                         bus_owner, bus_addr);
            end else begin
                eg = gnt_q.pop_front();
                if (bus_owner !== eg.owner || bus_req !== eg.req || bus_addr !== eg.addr ||
                    bus_wdata !== eg.wdata || bus_size !== eg.size) begin
                    miscompares++;
                    $display("FAIL grant: got owner=%0d req=%0d addr=%h wdata=%h size=%0d, expected owner=%0d req=%0d addr=%h wdata=%h size=%0d",
                             bus_owner, bus_req, bus_addr, bus_wdata, bus_size,
                             eg.owner, eg.req, eg.addr, eg.wdata, eg.size);
                end
            end
        end
        prev_bv = bus_valid;
    end

    // Response monitor: every ready pulse must match the next expected response.
    always @(negedge clk) begin
        if (if_ready || mem_ready) begin
            vectors++;
            if (if_ready && mem_ready) begin
                miscompares++;
                $display("FAIL response: both readies high, expected at most one");
            end else if (rsp_q.size() == 0) begin
                miscompares++;
                $display("FAIL response: unexpected ready on port %0d, none expected", mem_ready);
            end else begin
                er = rsp_q.pop_front();
                if (mem_ready !== er.port ||
                    (mem_ready ? mem_resp : if_resp) !== er.resp ||
                    (mem_ready ? mem_data_read : if_data_read) !== er.data ||
                    (mem_ready ? if_resp : mem_resp) !== 2'b00 ||
                    (mem_ready ? if_data_read : mem_data_read) !== '0) begin
                    miscompares++;
                    $display("FAIL response: got port=%0d resp=%0d data=%h, expected port=%0d resp=%0d data=%h (other port zero)",
                             mem_ready, mem_ready ? mem_resp : if_resp,
                             mem_ready ? mem_data_read : if_data_read,
                             er.port, er.resp, er.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b0;
        if_valid = 1'b0; if_addr = '0; if_size = 2'b00;
        mem_valid = 1'b0; mem_req = REQ_READ; mem_addr = '0; mem_data_write = '0;
        mem_size = 2'b00;
        bus_ready = 1'b0; bus_resp = 2'b00; bus_rdata = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        step();

        // Contention right after reset: MEM store wins, IF follows after an idle cycle.
        if_valid = 1'b1; if_addr = 64'h8000_0100; if_size = 2'b10;
        mem_valid = 1'b1; mem_req = REQ_WRITE; mem_addr = 64'h8000_1000;
        mem_data_write = 64'hDEAD_BEEF; mem_size = 2'b11;
        push_gnt(OWNER_MEM, REQ_WRITE, 64'h8000_1000, 64'hDEAD_BEEF, 2'b11);
        push_gnt(OWNER_IF, REQ_READ, 64'h8000_0100, 64'h0, 2'b10);
        push_rsp(OWNER_MEM, RESP_OKAY, 64'h0);
        complete(1, RESP_OKAY, 64'h0, 1'b0, 1'b1);
        check("idle_gap_1", 64'(bus_valid), 64'd0);
        push_rsp(OWNER_IF, RESP_OKAY, 64'h1111);
        complete(0, RESP_OKAY, 64'h1111, 1'b1, 1'b0);

        // Second simultaneous pair: MEM again, since IF went last.
        if_valid = 1'b1; if_addr = 64'h8000_0200;
        mem_valid = 1'b1; mem_req = REQ_READ; mem_addr = 64'h8000_1008;
        push_gnt(OWNER_MEM, REQ_READ, 64'h8000_1008, 64'hDEAD_BEEF, 2'b11);
        push_gnt(OWNER_IF, REQ_READ, 64'h8000_0200, 64'h0, 2'b10);
        push_rsp(OWNER_MEM, RESP_OKAY, 64'h5555);
        complete(0, RESP_OKAY, 64'h5555, 1'b0, 1'b1);
        check("idle_gap_2", 64'(bus_valid), 64'd0);
        push_rsp(OWNER_IF, RESP_OKAY, 64'h6666);
        complete(2, RESP_OKAY, 64'h6666, 1'b1, 1'b0);

        // Single fetch, bus_ready three cycles after bus_valid.
        if_valid = 1'b1; if_addr = 64'h8000_0000; if_size = 2'b10;
        push_gnt(OWNER_IF, REQ_READ, 64'h8000_0000, 64'h0, 2'b10);
        push_rsp(OWNER_IF, RESP_OKAY, 64'h13);
        complete(3, RESP_OKAY, 64'h13, 1'b1, 1'b0);

        // Abandon: fetch dropped then re-issued at a new address.
        step();
        if_valid = 1'b1; if_addr = 64'h8000_0000;
        push_gnt(OWNER_IF, REQ_READ, 64'h8000_0000, 64'h0, 2'b10);
        wait_grant(ok);
        check("abandon_grant_timeout", 64'(ok), 64'd1);
        step();
        if_valid = 1'b0;
        step();
        if_addr = 64'h8000_0040; if_valid = 1'b1;
        step();
        check("abandon_addr_hold", bus_addr, 64'h8000_0000);
        bus_ready = 1'b1; bus_rdata = 64'hBAD;
        #3;
        check("abandon_no_if_ready", 64'(if_ready), 64'd0);
        step();
        bus_ready = 1'b0; bus_rdata = '0;
        check("abandon_idle", 64'(bus_valid), 64'd0);
        push_gnt(OWNER_IF, REQ_READ, 64'h8000_0040, 64'h0, 2'b10);
        push_rsp(OWNER_IF, RESP_OKAY, 64'h2222);
        complete(1, RESP_OKAY, 64'h2222, 1'b1, 1'b0);

        // Stray bus_ready in idle with an error code.
        step();
        bus_ready = 1'b1; bus_resp = 2'b10; bus_rdata = 64'hFFFF;
        #3;
        check("spurious_if_ready", 64'(if_ready), 64'd0);
        check("spurious_mem_ready", 64'(mem_ready), 64'd0);
        step();
        bus_ready = 1'b0; bus_resp = 2'b00; bus_rdata = '0;
        check("spurious_stay_idle", 64'(bus_valid), 64'd0);

        // Error response on a MEM load.
        mem_valid = 1'b1; mem_req = REQ_READ; mem_addr = 64'h8000_2000; mem_size = 2'b11;
        push_gnt(OWNER_MEM, REQ_READ, 64'h8000_2000, 64'hDEAD_BEEF, 2'b11);
        push_rsp(OWNER_MEM, 2'b10, 64'hCAFE);
        complete(2, 2'b10, 64'hCAFE, 1'b0, 1'b1);
        check("err_idle", 64'(bus_valid), 64'd0);

        // Async reset while BUSY_MEM, then a late bus_ready that must be ignored.
        mem_valid = 1'b1; mem_addr = 64'h8000_3000;
        push_gnt(OWNER_MEM, REQ_READ, 64'h8000_3000, 64'hDEAD_BEEF, 2'b11);
        wait_grant(ok);
        check("rst_grant_timeout", 64'(ok), 64'd1);
        step();
        #2;
        rst = 1'b0;
        #1;
        check_zero("rst_busy");
        mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        bus_ready = 1'b1; bus_rdata = 64'h77;
        #3;
        check("late_if_ready", 64'(if_ready), 64'd0);
        check("late_mem_ready", 64'(mem_ready), 64'd0);
        step();
        bus_ready = 1'b0; bus_rdata = '0;
        check("late_stay_idle", 64'(bus_valid), 64'd0);

        // First contention after reset grants MEM.
        if_valid = 1'b1; if_addr = 64'h8000_0300;
        mem_valid = 1'b1; mem_req = REQ_WRITE; mem_addr = 64'h8000_4000;
        mem_data_write = 64'h1234_5678;
        push_gnt(OWNER_MEM, REQ_WRITE, 64'h8000_4000, 64'h1234_5678, 2'b11);
        push_gnt(OWNER_IF, REQ_READ, 64'h8000_0300, 64'h0, 2'b10);
        push_rsp(OWNER_MEM, RESP_OKAY, 64'h0);
        complete(0, RESP_OKAY, 64'h0, 1'b0, 1'b1);
        push_rsp(OWNER_IF, RESP_OKAY, 64'h3333);
        complete(1, RESP_OKAY, 64'h3333, 1'b1, 1'b0);

        repeat (3) step();
        check("grant_queue_drained", 64'(gnt_q.size()), 64'd0);
        check("resp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
